// File: rtl/muldiv_e.sv
// muldiv_e: iterative multiply/divide unit for the execute stage.
// It owns the HI/LO registers. One radix-2 step runs per cycle for WIDTH
// cycles, and one sign-fix cycle follows. busy tells the hazard unit to
// stall while an operation is in flight.
// Handshake: a start sampled in IDLE launches an operation. start, mthi and
// mtlo are all ignored while busy is high. done pulses for exactly one cycle
// once HI/LO hold the result.
module muldiv_e #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_q;      // product / quotient must be negated
    logic               neg_r;      // remainder takes the dividend's negative sign
    logic [WIDTH-1:0]   acc;        // product upper half / partial remainder
    logic [WIDTH-1:0]   low;        // multiplier -> product lower half / dividend -> quotient
    logic [WIDTH-1:0]   breg;       // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   raw_a;      // dividend as given, returned on divide by zero

    logic               sgn_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign busy = (state != IDLE);

    // The state register is the only sequential part of the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic. RUN leaves after step WIDTH-1.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand magnitudes, one radix-2 step, and the final sign fix.
    // A most-negative operand maps to itself, which is its correct unsigned
    // magnitude.
    always_comb begin
        sgn_op    = ~op[0];
        a_mag     = (sgn_op && srca[WIDTH-1]) ? ('0 - srca) : srca;
        b_mag     = (sgn_op && srcb[WIDTH-1]) ? ('0 - srcb) : srcb;
        mul_sum   = {1'b0, acc} + (low[0] ? {1'b0, breg} : '0);
        div_shift = {acc, low[WIDTH-1]};
        div_diff  = div_shift - {1'b0, breg};
        div_ge    = (div_shift >= {1'b0, breg});
        prod      = {acc, low};
        prod_fix  = neg_q ? ('0 - prod) : prod;
        fix_hi    = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo    = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (breg == '0) begin
                fix_lo = '1;
                fix_hi = raw_a;
            end else begin
                fix_lo = neg_q ? ('0 - low) : low;
                fix_hi = neg_r ? ('0 - acc) : acc;
            end
        end
    end

    // Datapath: launch or MTHI/MTLO in IDLE, iterate in RUN, commit in FIX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            low    <= '0;
            breg   <= '0;
            raw_a  <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        is_div <= op[1];
                        neg_q  <= sgn_op & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        neg_r  <= sgn_op & srca[WIDTH-1];
                        acc    <= '0;
                        low    <= a_mag;
                        breg   <= b_mag;
                        raw_a  <= srca;
                        // Multiply keeps the multiplier in low, the multiplicand in breg.
                        if (!op[1]) begin
                            low  <= b_mag;
                            breg <= a_mag;
                        end
                    end else begin
                        if (mthi) hi <= srca;
                        if (mtlo) lo <= srca;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div) begin
                        acc <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        low <= {low[WIDTH-2:0], div_ge};
                    end else begin
                        {acc, low} <= {mul_sum, low[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_e.sv
// Testbench for muldiv_e. Directed vectors carry hand-computed HI/LO values.
// The driver pushes the expected {hi, lo} pair as it issues each operation.
// A monitor pops and compares the pair whenever done is high.
module tb_muldiv_e;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] srca, srcb;
  logic         mthi, mtlo;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  logic [2*W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  logic done_d = 1'b0;

  muldiv_e #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [2*W-1:0] e;
      check("done_single_pulse", {31'd0, done_d}, 32'd0);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no result", hi, lo);
      end else begin
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin
          fails++;
          $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e[2*W-1:W], e[W-1:0]);
        end
      end
    end
    done_d <= done;
  end

  // driver: idle inputs are scrambled so latched operands are the only valid source
  task automatic scramble();
    op = 2'($urandom_range(0, 3));
    srca = $urandom;
    srcb = $urandom;
  endtask

  task automatic wait_idle(input string name, output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 100) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, cycles);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input bit chk_lat);
    int cyc;
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    exp_q.push_back({eh, el});
    @(negedge clk);
    start = 1'b0;
    scramble();
    wait_idle(name, cyc);
    if (chk_lat) check({name, "_busy_cycles"}, W'(cyc), 32'd33);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; srca = '0; srcb = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // MTHI + MTLO together
    mthi = 1'b1; mtlo = 1'b1; srca = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0; srca = '0;
    check("mthilo_hi", hi, 32'hA5A5_A5A5);
    check("mthilo_lo", lo, 32'hA5A5_A5A5);
    check("mthilo_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a MULTU: abort, no late result
    start = 1'b1; op = 2'b01; srca = 32'h1234_5678; srcb = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    repeat (40) @(negedge clk);
    check("midreset_hi_late", hi, 32'd0);
    check("midreset_lo_late", lo, 32'd0);

    // Directed vectors
    run_op("mult_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_m1_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0);
    run_op("multu_2p16", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    run_op("div_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
    run_op("div_minneg", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("divu_by0", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    run_op("div_by0", 2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0);

    // Second start plus mthi during RUN: both ignored
    @(negedge clk);
    start = 1'b1; op = 2'b11; srca = 32'd100; srcb = 32'd7;
    exp_q.push_back({32'd2, 32'd14});
    @(negedge clk);
    start = 1'b0; scramble();
    repeat (5) @(negedge clk);
    start = 1'b1; mthi = 1'b1; op = 2'b00; srca = 32'h0000_DEAD; srcb = 32'd3;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    check("run_hi_hold", hi, 32'hFFFF_FFF0);
    check("run_lo_hold", lo, 32'hFFFF_FFFF);
    wait_idle("collide", cyc);
    @(negedge clk);
    check("collide_no_relaunch", {31'd0, busy}, 32'd0);

    // Start together with mtlo in IDLE: start wins, lo untouched until FIX
    mtlo = 1'b1; srca = 32'h1111_1111;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_only", lo, 32'h1111_1111);
    start = 1'b1; mtlo = 1'b1; op = 2'b00; srca = 32'd7; srcb = 32'hFFFF_FFFD;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0; scramble();
    check("start_mtlo_busy", {31'd0, busy}, 32'd1);
    check("start_mtlo_lo", lo, 32'h1111_1111);
    wait_idle("start_mtlo", cyc);
    repeat (3) @(negedge clk);

    check("scoreboard_empty", W'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
